// File: rtl/aes_round_sequencer_if.sv
// rtl/aes_round_sequencer_if.sv - request, key-expansion and datapath-control bundle for the AES round sequencer
interface aes_round_sequencer_if;
  logic       start;
  logic       encOrDec;
  logic [2:0] keySize;
  logic       key_ready;
  logic       key_req;
  logic       ld_msg;
  logic       sub_en;
  logic       shift_en;
  logic       mix_en;
  logic       ark_en;
  logic       inv;
  logic [3:0] round_idx;
  logic       busy;
  logic       doneE;
  logic       doneD;
  logic       err;

  modport master (
    output start, encOrDec, keySize, key_ready,
    input  key_req, ld_msg, sub_en, shift_en, mix_en, ark_en, inv,
    input  round_idx, busy, doneE, doneD, err
  );

  modport slave (
    input  start, encOrDec, keySize, key_ready,
    output key_req, ld_msg, sub_en, shift_en, mix_en, ark_en, inv,
    output round_idx, busy, doneE, doneD, err
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - steps the one-round-per-cycle AES datapath through ARK, Nr-1 rounds and the final round
module aes_round_sequencer #(
  parameter int KEY_WAIT_MAX = 255
) (
  input logic                  clk,
  input logic                  rst,
  aes_round_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [8:0] WAIT_LIMIT = 9'(KEY_WAIT_MAX);

  state_t     state, stateNext;
  logic [7:0] waitCnt, waitCntNext;
  logic [3:0] roundCnt, roundCntNext;
  logic       encLat, encNext;
  logic [3:0] nrLat, nrNext;
  logic       errEvent;

  logic       keyReqReg, ldMsgReg, subReg, shiftReg, mixReg, arkReg, invReg;
  logic       busyReg, doneEReg, doneDReg, errReg;
  logic [3:0] roundIdxReg;

  logic       keyReqNext, ldMsgNext, subNext, shiftNext, mixNext, arkNext, invNext;
  logic       busyNext, doneENext, doneDNext, errNext;
  logic [3:0] roundIdxNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      waitCnt     <= '0;
      roundCnt    <= '0;
      encLat      <= 1'b0;
      nrLat       <= '0;
      keyReqReg   <= 1'b0;
      ldMsgReg    <= 1'b0;
      subReg      <= 1'b0;
      shiftReg    <= 1'b0;
      mixReg      <= 1'b0;
      arkReg      <= 1'b0;
      invReg      <= 1'b0;
      busyReg     <= 1'b0;
      doneEReg    <= 1'b0;
      doneDReg    <= 1'b0;
      errReg      <= 1'b0;
      roundIdxReg <= '0;
    end else begin
      state       <= stateNext;
      waitCnt     <= waitCntNext;
      roundCnt    <= roundCntNext;
      encLat      <= encNext;
      nrLat       <= nrNext;
      keyReqReg   <= keyReqNext;
      ldMsgReg    <= ldMsgNext;
      subReg      <= subNext;
      shiftReg    <= shiftNext;
      mixReg      <= mixNext;
      arkReg      <= arkNext;
      invReg      <= invNext;
      busyReg     <= busyNext;
      doneEReg    <= doneENext;
      doneDReg    <= doneDNext;
      errReg      <= errNext;
      roundIdxReg <= roundIdxNext;
    end
  end

  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    roundCntNext = roundCnt;
    encNext      = encLat;
    nrNext       = nrLat;
    errEvent     = 1'b0;
    case (state)
      IDLE: begin
        waitCntNext  = '0;
        roundCntNext = '0;
        if (bus.start) begin
          case (bus.keySize)
            3'b100: begin nrNext = 4'd10; encNext = bus.encOrDec; stateNext = KEYEXP; end
            3'b010: begin nrNext = 4'd12; encNext = bus.encOrDec; stateNext = KEYEXP; end
            3'b001: begin nrNext = 4'd14; encNext = bus.encOrDec; stateNext = KEYEXP; end
            default: errEvent = 1'b1;
          endcase
        end
      end
      KEYEXP: begin
        waitCntNext = waitCnt + 8'd1;
        // key_ready takes priority over a timeout landing in the same cycle
        if (bus.key_ready) begin
          stateNext = INIT;
        end else if (({1'b0, waitCnt} + 9'd1) == WAIT_LIMIT) begin
          stateNext = IDLE;
          errEvent  = 1'b1;
        end
      end
      INIT: begin
        waitCntNext  = '0;
        roundCntNext = 4'd1;
        stateNext    = ROUND;
      end
      ROUND: begin
        if (roundCnt == nrLat - 4'd1) begin
          roundCntNext = '0;
          stateNext    = FINAL;
        end else begin
          roundCntNext = roundCnt + 4'd1;
        end
      end
      FINAL:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies line up with it
  always_comb begin
    keyReqNext   = (stateNext == KEYEXP);
    ldMsgNext    = (stateNext == INIT);
    subNext      = (stateNext == ROUND) || (stateNext == FINAL);
    shiftNext    = (stateNext == ROUND) || (stateNext == FINAL);
    mixNext      = (stateNext == ROUND);
    arkNext      = (stateNext == INIT) || (stateNext == ROUND) || (stateNext == FINAL);
    busyNext     = (stateNext != IDLE);
    invNext      = (stateNext != IDLE) && !encNext;
    doneENext    = (stateNext == DONE) && encNext;
    doneDNext    = (stateNext == DONE) && !encNext;
    errNext      = errEvent;
    roundIdxNext = '0;
    case (stateNext)
      INIT:    roundIdxNext = encNext ? 4'd0 : nrNext;
      ROUND:   roundIdxNext = encNext ? roundCntNext : (nrNext - roundCntNext);
      FINAL:   roundIdxNext = encNext ? nrNext : 4'd0;
      default: roundIdxNext = '0;
    endcase
  end

  assign bus.key_req   = keyReqReg;
  assign bus.ld_msg    = ldMsgReg;
  assign bus.sub_en    = subReg;
  assign bus.shift_en  = shiftReg;
  assign bus.mix_en    = mixReg;
  assign bus.ark_en    = arkReg;
  assign bus.inv       = invReg;
  assign bus.round_idx = roundIdxReg;
  assign bus.busy      = busyReg;
  assign bus.doneE     = doneEReg;
  assign bus.doneD     = doneDReg;
  assign bus.err       = errReg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed self-checking bench for aes_round_sequencer
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  logic rst;

  aes_round_sequencer_if bus();

  aes_round_sequencer #(.KEY_WAIT_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  // Per-cycle observations; index c is the c-th cycle after the start edge
  logic [3:0] oIdx    [0:39];
  logic       oArk    [0:39];
  logic       oMix    [0:39];
  logic       oSub    [0:39];
  logic       oLd     [0:39];
  logic       oInv    [0:39];
  logic       oBusy   [0:39];
  logic       oKeyReq [0:39];
  logic       oDoneE  [0:39];
  logic       oDoneD  [0:39];
  logic       oErr    [0:39];

  function automatic logic [14:0] outVec();
    return {bus.key_req, bus.ld_msg, bus.sub_en, bus.shift_en, bus.mix_en, bus.ark_en,
            bus.inv, bus.busy, bus.doneE, bus.doneD, bus.err, bus.round_idx};
  endfunction

  // Starts an operation at the current negedge and records nCycles cycles of outputs
  task automatic runOp(input logic enc, input logic [2:0] ks, input logic [2:0] ksAfter,
                       input int readyCycle, input int restartAt, input int nCycles);
    bus.encOrDec  = enc;
    bus.keySize   = ks;
    bus.start     = 1'b1;
    bus.key_ready = (readyCycle <= 0);
    for (int c = 1; c <= nCycles; c++) begin
      @(negedge clk);
      oIdx[c]    = bus.round_idx;
      oArk[c]    = bus.ark_en;
      oMix[c]    = bus.mix_en;
      oSub[c]    = bus.sub_en;
      oLd[c]     = bus.ld_msg;
      oInv[c]    = bus.inv;
      oBusy[c]   = bus.busy;
      oKeyReq[c] = bus.key_req;
      oDoneE[c]  = bus.doneE;
      oDoneD[c]  = bus.doneD;
      oErr[c]    = bus.err;
      bus.start     = (c == restartAt);
      bus.keySize   = ksAfter;
      bus.key_ready = (c >= readyCycle);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.encOrDec = 1'b0; bus.keySize = 3'b000; bus.key_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    totalCnt++;
    if (outVec() !== 15'd0) $display("FAIL reset_outputs: got %h want 0000", outVec());
    else passCnt++;
    rst = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (outVec() !== 15'd0) $display("FAIL idle_after_reset: got %h want 0000", outVec());
    else passCnt++;
  endtask

  task automatic test_encrypt_128();
    logic [6:0] got, want;
    logic [4:0] sGot, sWant;
    runOp(1'b1, 3'b100, 3'b100, 0, 0, 14);
    for (int c = 2; c <= 12; c++) begin
      got  = {oArk[c], oMix[c], oSub[c], oInv[c], oIdx[c][2:0]};
      want = {1'b1, (c >= 3 && c <= 11), (c >= 3), 1'b0, 3'(c - 2)};
      totalCnt++;
      if (got !== want || oIdx[c] !== 4'(c - 2))
        $display("FAIL enc128_round c=%0d: got ark/mix/sub/inv/idx %b idx=%0d want %b idx=%0d", c, got, oIdx[c], want, c - 2);
      else passCnt++;
    end
    for (int c = 1; c <= 14; c++) begin
      sGot  = {oDoneE[c], oDoneD[c], oLd[c], oKeyReq[c], oBusy[c]};
      sWant = {(c == 13), 1'b0, (c == 2), (c == 1), (c <= 13)};
      totalCnt++;
      if (sGot !== sWant) $display("FAIL enc128_status c=%0d: got %b want %b", c, sGot, sWant);
      else passCnt++;
    end
  endtask

  task automatic test_decrypt_256();
    logic [7:0] got, want;
    logic [5:0] sGot, sWant;
    runOp(1'b0, 3'b001, 3'b001, 4, 0, 21);
    for (int c = 5; c <= 19; c++) begin
      got  = {oArk[c], oMix[c], oInv[c], oLd[c], oIdx[c]};
      want = {1'b1, (c >= 6 && c <= 18), 1'b1, (c == 5), 4'(19 - c)};
      totalCnt++;
      if (got !== want) $display("FAIL dec256_round c=%0d: got %b want %b", c, got, want);
      else passCnt++;
    end
    for (int c = 1; c <= 21; c++) begin
      sGot  = {oDoneE[c], oDoneD[c], oKeyReq[c], oBusy[c], oInv[c], oErr[c]};
      sWant = {1'b0, (c == 20), (c <= 4), (c <= 20), (c <= 20), 1'b0};
      totalCnt++;
      if (sGot !== sWant) $display("FAIL dec256_status c=%0d: got %b want %b", c, sGot, sWant);
      else passCnt++;
    end
  endtask

  task automatic test_bad_keysize();
    logic [2:0] got, want;
    runOp(1'b1, 3'b011, 3'b011, 0, 0, 4);
    for (int c = 1; c <= 4; c++) begin
      got  = {oErr[c], oBusy[c], oKeyReq[c]};
      want = {(c == 1), 1'b0, 1'b0};
      totalCnt++;
      if (got !== want) $display("FAIL bad_keysize c=%0d: got err/busy/key_req %b want %b", c, got, want);
      else passCnt++;
    end
  endtask

  task automatic test_key_timeout();
    logic [5:0] got, want;
    runOp(1'b1, 3'b100, 3'b100, 99, 0, 8);
    for (int c = 1; c <= 8; c++) begin
      got  = {oErr[c], oBusy[c], oKeyReq[c], oDoneE[c], oDoneD[c], oLd[c]};
      want = {(c == 5), (c <= 4), (c <= 4), 1'b0, 1'b0, 1'b0};
      totalCnt++;
      if (got !== want) $display("FAIL key_timeout c=%0d: got %b want %b", c, got, want);
      else passCnt++;
    end
  endtask

  task automatic test_reset_mid_round();
    runOp(1'b1, 3'b100, 3'b100, 0, 0, 7);
    totalCnt++;
    if (oIdx[7] !== 4'd5 || oMix[7] !== 1'b1)
      $display("FAIL pre_reset_round: got idx=%0d mix=%b want idx=5 mix=1", oIdx[7], oMix[7]);
    else passCnt++;
    rst = 1'b1;
    @(negedge clk);
    totalCnt++;
    if (outVec() !== 15'd0) $display("FAIL mid_round_reset: got %h want 0000", outVec());
    else passCnt++;
    rst = 1'b0;
    runOp(1'b1, 3'b100, 3'b100, 0, 0, 14);
    for (int c = 11; c <= 14; c++) begin
      totalCnt++;
      if (oDoneE[c] !== (c == 13) || oErr[c] !== 1'b0)
        $display("FAIL restart_after_reset c=%0d: got doneE=%b err=%b want doneE=%b err=0", c, oDoneE[c], oErr[c], (c == 13));
      else passCnt++;
    end
    totalCnt++;
    if (oIdx[12] !== 4'd10) $display("FAIL restart_final_idx: got %0d want 10", oIdx[12]);
    else passCnt++;
  endtask

  task automatic test_ignore_changes();
    logic [6:0] got, want;
    runOp(1'b1, 3'b100, 3'b010, 0, 6, 16);
    for (int c = 1; c <= 16; c++) begin
      got  = {oDoneE[c], oBusy[c], oArk[c], oIdx[c]};
      want = {(c == 13), (c <= 13), (c >= 2 && c <= 12), ((c >= 2 && c <= 12) ? 4'(c - 2) : 4'd0)};
      totalCnt++;
      if (got !== want) $display("FAIL ignore_changes c=%0d: got %b want %b", c, got, want);
      else passCnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got, want;
    runOp(1'b1, 3'b100, 3'b100, 0, 14, 28);
    for (int c = 1; c <= 28; c++) begin
      got  = {oDoneE[c], oBusy[c], oKeyReq[c]};
      want = {(c == 13 || c == 27), (c <= 13 || (c >= 15 && c <= 27)), (c == 1 || c == 15)};
      totalCnt++;
      if (got !== want) $display("FAIL back_to_back c=%0d: got doneE/busy/key_req %b want %b", c, got, want);
      else passCnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.encOrDec = 1'b0; bus.keySize = 3'b000; bus.key_ready = 1'b0;
    test_reset();
    test_encrypt_128();
    test_decrypt_256();
    test_bad_keysize();
    test_key_timeout();
    test_reset_mid_round();
    test_ignore_changes();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
